// File: rtl/ci_fir_mac_if.sv
// Nios II multi-cycle custom-instruction port bundle for ci_fir_mac.
//   clk_en  CI clock enable (state frozen when low)
//   start   CI start strobe
//   n       operation select
//   dataa   operand A (index or sample)
//   datab   operand B (coefficient value)
//   result  registered CI result
//   done    one-cycle completion pulse
// master: the Nios II core side; slave: the custom-instruction block.
interface ci_fir_mac_if;
  logic        clk_en;
  logic        start;
  logic [2:0]  n;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  modport master (
    output clk_en, start, n, dataa, datab,
    input  result, done
  );

  modport slave (
    input  clk_en, start, n, dataa, datab,
    output result, done
  );
endinterface

// File: rtl/ci_fir_mac.sv
// Multi-cycle custom instruction: fixed-point FIR filter with on-chip coefficient
// and circular sample-history storage, one shared multiplier, one MAC per enabled cycle.
// Operations (ci.n): 0 write coef, 1 filter one sample, 2 read coef, 3 clear history,
// 4 read status {15'b0, sat, TAPS[15:0]} (clears sat), 5..7 no-op returning 0.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   ci     custom-instruction slave port (clk_en, start, n, dataa, datab, result, done)
module ci_fir_mac #(
  parameter int unsigned TAPS      = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned FRAC_BITS = 15,
  parameter int unsigned ACC_W     = 40
) (
  input logic         clk,
  input logic         reset,
  ci_fir_mac_if.slave ci
);

  localparam int unsigned IdxW  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned ProdW = DATA_W + COEF_W;

  localparam logic [IdxW-1:0] LastTap = IdxW'(TAPS - 1);
  localparam logic [15:0]     TapsW   = 16'(TAPS);

  // Saturation bounds of the DATA_W output, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SatMax =
    {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin =
    {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  if (ACC_W < DATA_W + COEF_W + $clog2(TAPS)) begin : g_acc_w_check
    $error("ci_fir_mac: ACC_W too small for DATA_W+COEF_W+clog2(TAPS)");
  end
  if (TAPS < 2 || TAPS > 64) begin : g_taps_check
    $error("ci_fir_mac: TAPS must be in 2..64");
  end
  if (DATA_W > 32 || COEF_W > 32) begin : g_width_check
    $error("ci_fir_mac: DATA_W and COEF_W must be <= 32");
  end

  typedef enum logic [1:0] {StIdle, StMac, StFin} state_e;

  state_e                   state_q;
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [DATA_W-1:0] hist_q [TAPS];
  logic [IdxW-1:0]          wp_q;
  logic [IdxW-1:0]          k_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     sat_q;
  logic [31:0]              result_q;

  logic                     in_range;
  logic [IdxW-1:0]          idx;
  logic signed [COEF_W-1:0] coef_rd;
  logic signed [31:0]       coef_ext;
  logic [IdxW-1:0]          hist_idx;
  logic signed [ProdW-1:0]  prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_shift;
  logic signed [ACC_W-1:0]  y_sat;
  logic signed [DATA_W-1:0] y_narrow;
  logic signed [31:0]       y_ext;
  logic                     clip;
  logic                     unused_datab;

  // Only the low COEF_W bits of datab carry a coefficient.
  assign unused_datab = ^ci.datab;

  always_comb begin
    // Full 32-bit compare so large indices alias to nothing rather than wrapping.
    in_range = (ci.dataa < TAPS);
    idx      = ci.dataa[IdxW-1:0];
    coef_rd  = in_range ? coef_q[idx] : '0;
    coef_ext = coef_rd;

    // Tap k pairs with the sample k steps older than the newest one at wp.
    if (wp_q >= k_q) begin
      hist_idx = wp_q - k_q;
    end else begin
      hist_idx = IdxW'(TAPS - 32'(k_q) + 32'(wp_q));
    end

    prod      = coef_q[k_q] * hist_q[hist_idx];
    prod_ext  = prod;
    acc_sum   = acc_q + prod_ext;
    acc_shift = acc_sum >>> FRAC_BITS;

    clip  = 1'b0;
    y_sat = acc_shift;
    if (acc_shift > SatMax) begin
      y_sat = SatMax;
      clip  = 1'b1;
    end else if (acc_shift < SatMin) begin
      y_sat = SatMin;
      clip  = 1'b1;
    end
    y_narrow = y_sat[DATA_W-1:0];
    y_ext    = y_narrow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      wp_q     <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
      result_q <= '0;
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
        hist_q[i] <= '0;
      end
    end else if (ci.clk_en) begin
      unique case (state_q)
        StIdle: begin
          if (ci.start) begin
            state_q <= StFin;
            case (ci.n)
              3'd0: begin
                if (in_range) coef_q[idx] <= ci.datab[COEF_W-1:0];
                result_q <= '0;
              end
              3'd1: begin
                hist_q[wp_q] <= ci.dataa[DATA_W-1:0];
                acc_q        <= '0;
                k_q          <= '0;
                state_q      <= StMac;
              end
              3'd2: result_q <= coef_ext;
              3'd3: begin
                for (int i = 0; i < TAPS; i++) hist_q[i] <= '0;
                wp_q     <= '0;
                result_q <= '0;
              end
              3'd4: begin
                result_q <= {15'b0, sat_q, TapsW};
                sat_q    <= 1'b0;
              end
              default: result_q <= '0;
            endcase
          end
        end
        StMac: begin
          if (k_q == LastTap) begin
            result_q <= y_ext;
            if (clip) sat_q <= 1'b1;
            wp_q    <= (wp_q == LastTap) ? '0 : wp_q + IdxW'(1);
            state_q <= StFin;
          end else begin
            acc_q <= acc_sum;
            k_q   <= k_q + IdxW'(1);
          end
        end
        StFin:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ci.result = result_q;
  // Completion is only signalled on an enabled cycle.
  assign ci.done   = (state_q == StFin) & ci.clk_en;

endmodule

// File: tb/tb_ci_fir_mac.sv
module tb_ci_fir_mac;
  localparam int TAPS = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ci_fir_mac_if ci ();

  ci_fir_mac #(
    .TAPS(TAPS), .DATA_W(16), .COEF_W(16), .FRAC_BITS(15), .ACC_W(40)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ci   (ci)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: coefficients plus a history line with the newest sample at index 0.
  int coef_m [TAPS];
  int hist_m [TAPS];
  bit sat_m;

  logic [31:0] exp_res;
  logic [31:0] held_res;
  bit          pending = 0;
  bit          chk_en  = 0;
  bit          prev_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      coef_m[i] = 0;
      hist_m[i] = 0;
    end
    sat_m = 0;
  endfunction

  function automatic logic [31:0] model_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sum;
    longint y;
    logic [31:0] r;
    r = '0;
    case (op)
      3'd0: if (a < TAPS) coef_m[a] = $signed(b[15:0]);
      3'd1: begin
        for (int i = TAPS - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
        hist_m[0] = $signed(a[15:0]);
        sum = 0;
        for (int i = 0; i < TAPS; i++) sum += longint'(coef_m[i]) * longint'(hist_m[i]);
        y = sum >>> 15;
        if (y > 32767) begin
          y = 32767;
          sat_m = 1;
        end else if (y < -32768) begin
          y = -32768;
          sat_m = 1;
        end
        r = y[31:0];
      end
      3'd2: if (a < TAPS) r = coef_m[a];
      3'd3: for (int i = 0; i < TAPS; i++) hist_m[i] = 0;
      3'd4: begin
        r = {15'b0, sat_m, 16'(TAPS)};
        sat_m = 0;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Every cycle: a done must be expected, enabled, isolated and carry the model result;
  // otherwise result must hold the last completed value.
  always @(negedge clk) begin
    if (chk_en) begin
      if (ci.done) begin
        check("done_needs_clk_en", 32'(ci.clk_en), 32'd1);
        check("done_not_back_to_back", 32'(prev_done), 32'd0);
        check("done_expected", 32'(pending), 32'd1);
        if (pending) begin
          check("result", ci.result, exp_res);
          held_res = exp_res;
          pending  = 0;
        end
      end else begin
        check("result_hold", ci.result, held_res);
      end
      prev_done = ci.done;
    end
  end

  // Issue one CI op; lat is the expected start-to-done distance in clock cycles.
  // inject_at > 0 pulses a CLRHIST start that many cycles in, which must be ignored.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int inject_at, output logic [31:0] res);
    int cyc;
    @(posedge clk);
    #1;
    exp_res  = model_op(op, a, b);
    pending  = 1;
    ci.start = 1'b1;
    ci.n     = op;
    ci.dataa = a;
    ci.datab = b;
    @(posedge clk);
    #1;
    ci.start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (inject_at > 0 && cyc == inject_at) begin
        ci.start = 1'b1;
        ci.n     = 3'd3;
      end else if (inject_at > 0 && cyc == inject_at + 1) begin
        ci.start = 1'b0;
        ci.n     = op;
      end
    end while (!ci.done && cyc < 300);
    if (!ci.done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: op %0d no done after %0d cycles", op, cyc);
      pending = 0;
    end else begin
      check("latency", 32'(cyc), 32'(lat));
    end
    ci.start = 1'b0;
    res = ci.result;
  endtask

  function automatic int op_lat(input logic [2:0] op);
    return (op == 3'd1) ? TAPS + 1 : 1;
  endfunction

  logic [31:0] res;
  logic [2:0]  rop;
  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    reset     = 1'b1;
    ci.clk_en = 1'b1;
    ci.start  = 1'b0;
    ci.n      = '0;
    ci.dataa  = '0;
    ci.datab  = '0;
    model_reset();
    held_res = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_result", ci.result, 32'h0);
    check("reset_done", 32'(ci.done), 32'h0);
    chk_en = 1;

    // 1: status and coefficient read after reset.
    run_op(3'd4, 0, 0, 1, 0, res);
    check("status_after_reset", res, 32'h0000_0010);
    run_op(3'd2, 3, 0, 1, 0, res);
    check("rdcoef_after_reset", res, 32'h0);

    // 2: 0.5 coefficients, impulse of 1000 passes through all taps.
    for (int i = 0; i < TAPS; i++) run_op(3'd0, i, 32'h4000, 1, 0, res);
    run_op(3'd1, 1000, 0, TAPS + 1, 0, res);
    check("impulse_first", res, 32'h0000_01F4);
    for (int i = 1; i < TAPS; i++) run_op(3'd1, 0, 0, TAPS + 1, 0, res);
    check("impulse_last_tap", res, 32'h0000_01F4);
    run_op(3'd1, 0, 0, TAPS + 1, 0, res);
    check("impulse_gone", res, 32'h0);

    // 3: positive and negative saturation, sticky flag cleared by STATUS.
    for (int i = 0; i < TAPS; i++) run_op(3'd0, i, 32'h7FFF, 1, 0, res);
    for (int i = 0; i < TAPS; i++) run_op(3'd1, 32'h7FFF, 0, TAPS + 1, 0, res);
    check("sat_pos", res, 32'h0000_7FFF);
    run_op(3'd4, 0, 0, 1, 0, res);
    check("status_sat_set", res, 32'h0001_0010);
    run_op(3'd4, 0, 0, 1, 0, res);
    check("status_sat_clr", res, 32'h0000_0010);
    for (int i = 0; i < TAPS; i++) run_op(3'd1, 32'h8000, 0, TAPS + 1, 0, res);
    check("sat_neg", res, 32'hFFFF_8000);
    run_op(3'd4, 0, 0, 1, 0, res);

    // 4: clk_en held low for 5 cycles while at MAC step 7.
    for (int i = 0; i < TAPS; i++) run_op(3'd0, i, $urandom_range(0, 16'h0FFF), 1, 0, res);
    for (int i = 0; i < 5; i++) run_op(3'd1, $urandom_range(0, 16'hFFFF), 0, TAPS + 1, 0, res);
    fork
      run_op(3'd1, 32'h0000_1234, 0, TAPS + 6, 0, res);
      begin
        repeat (9) @(posedge clk);
        #1 ci.clk_en = 1'b0;
        repeat (5) @(posedge clk);
        #1 ci.clk_en = 1'b1;
      end
    join

    // 5: reset while at MAC step 8 aborts without done and clears all storage.
    @(posedge clk);
    #1;
    ci.start = 1'b1;
    ci.n     = 3'd1;
    ci.dataa = 32'd5000;
    @(posedge clk);
    #1 ci.start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    held_res = '0;
    repeat (25) @(negedge clk);
    run_op(3'd2, 3, 0, 1, 0, res);
    check("rdcoef_after_abort", res, 32'h0);
    run_op(3'd1, 1234, 0, TAPS + 1, 0, res);
    check("filter_after_abort", res, 32'h0);

    // 6: out-of-range write, history clear, start ignored during MAC.
    for (int i = 0; i < TAPS; i++) run_op(3'd0, i, 32'h4000 + 32'(i), 1, 0, res);
    run_op(3'd0, TAPS, 32'h1234, 1, 0, res);
    for (int i = 0; i < TAPS; i++) run_op(3'd2, i, 0, 1, 0, res);
    run_op(3'd2, 5, 0, 1, 0, res);
    check("rdcoef_5", res, 32'h0000_4005);
    for (int i = 0; i < 4; i++) run_op(3'd1, 32'h2000, 0, TAPS + 1, 0, res);
    run_op(3'd3, 0, 0, 1, 0, res);
    run_op(3'd1, 0, 0, TAPS + 1, 0, res);
    check("filter_after_clrhist", res, 32'h0);
    run_op(3'd1, 32'h0100, 0, TAPS + 1, 5, res);
    repeat (3) @(negedge clk);
    run_op(3'd1, 0, 0, TAPS + 1, 0, res);

    // Random mix of every operation, including undefined n and out-of-range indices.
    for (int t = 0; t < 300; t++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = (rop == 3'd1) ? $urandom : 32'($urandom_range(0, TAPS + 4));
      if ($urandom_range(0, 9) == 0) ra = $urandom;
      rb  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 16'h0FFF));
      run_op(rop, ra, rb, op_lat(rop), 0, res);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
